// File: rtl/fe_atr_router_pkg.sv
// Purpose : shared types and constants for the radio-to-frontend ATR router.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package fe_atr_router_pkg;

  // Router state: RUN routes every lane, SETTLE holds broken lanes at the safe value.
  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  // Settings-bus register offsets relative to SR_BASE.
  localparam int SR_MAP    = 0;
  localparam int SR_SETTLE = 1;

  // Width of one frontend's source-select field, and the largest supported channel count.
  localparam int SEL_W  = 4;
  localparam int MAX_CH = 8;

  // Identity map (frontend i sourced from radio i) for the first n frontends.
  function automatic logic [SEL_W*MAX_CH-1:0] ident_map(input int n);
    logic [SEL_W*MAX_CH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < n) m[i*SEL_W +: SEL_W] = SEL_W'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/fe_atr_lane.sv
// Purpose : one frontend lane - picks a radio's ATR word, or the safe value, into an output flop.
// Latency : 1 cycle from radio_gpio/sel/force_safe to fe_dat.
// Backpressure: none; the lane samples every cycle.
// Ports: radio_clk/radio_rst_n clock and async active-low reset; radio_gpio all radio words;
//        sel source radio index; force_safe drive SAFE_VAL; fe_dat registered lane output.
module fe_atr_lane
  import fe_atr_router_pkg::*;
#(
  parameter int              NUM_CH   = 2,
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] SAFE_VAL = '0
) (
  input  logic                    radio_clk,
  input  logic                    radio_rst_n,
  input  logic [NUM_CH*WIDTH-1:0] radio_gpio,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    force_safe,
  output logic [WIDTH-1:0]        fe_dat
);

  logic [WIDTH-1:0] src_dat;
  logic [WIDTH-1:0] fe_d;
  logic [WIDTH-1:0] fe_q;

  // An index with no matching radio (sel >= NUM_CH) falls through to SAFE_VAL.
  always_comb begin
    src_dat = SAFE_VAL;
    for (int r = 0; r < NUM_CH; r++) begin
      if (sel == SEL_W'(r)) src_dat = radio_gpio[r*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    fe_d = force_safe ? SAFE_VAL : src_dat;
  end

  // Single output stage so the synthesiser can pack it into the IOB.
  always_ff @(posedge radio_clk or negedge radio_rst_n) begin
    if (!radio_rst_n) fe_q <= SAFE_VAL;
    else              fe_q <= fe_d;
  end

  assign fe_dat = fe_q;

endmodule

// File: rtl/fe_atr_router.sv
// Purpose : routes each radio's ATR word to any frontend with break-before-make on remap.
// Latency : 1 cycle radio_gpio->fe_gpio; remapped lanes are safe for settle+1 cycles.
// Backpressure: none; settings writes are always accepted, later MAP writes override earlier.
// Ports: radio_clk/radio_rst_n clock and async active-low reset; set_stb/set_addr/set_data
//        settings bus; hold forces all lanes safe; radio_gpio per-radio words; fe_gpio
//        registered per-frontend words; busy break/settle/hold in effect; rb_map readback.
module fe_atr_router
  import fe_atr_router_pkg::*;
#(
  parameter int               NUM_CH        = 2,
  parameter int               WIDTH         = 8,
  parameter int               SR_BASE       = 0,
  parameter logic [WIDTH-1:0] SAFE_VAL      = '0,
  parameter logic [15:0]      SETTLE_CYCLES = 16'd16
) (
  input  logic                    radio_clk,
  input  logic                    radio_rst_n,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  input  logic                    hold,
  input  logic [NUM_CH*WIDTH-1:0] radio_gpio,
  output logic [NUM_CH*WIDTH-1:0] fe_gpio,
  output logic                    busy,
  output logic [31:0]             rb_map
);

  localparam int MAP_W = SEL_W * NUM_CH;
  localparam logic [SEL_W*MAX_CH-1:0] IDENT_ALL = ident_map(NUM_CH);
  localparam logic [MAP_W-1:0]        IDENT_MAP = IDENT_ALL[MAP_W-1:0];

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       settle_q, settle_d;
  logic [NUM_CH-1:0] break_mask_q, break_mask_d;
  logic [MAP_W-1:0]  active_map_q, active_map_d;
  logic [MAP_W-1:0]  pending_map_q, pending_map_d;
  logic              busy_q, busy_d;

  logic              map_wr;
  logic              settle_wr;
  logic [MAP_W-1:0]  new_map;
  logic [NUM_CH-1:0] map_diff;
  logic              unused_set_data;

  assign map_wr          = set_stb && (set_addr == 8'(SR_BASE + SR_MAP));
  assign settle_wr       = set_stb && (set_addr == 8'(SR_BASE + SR_SETTLE));
  assign new_map         = set_data[MAP_W-1:0];
  assign unused_set_data = ^set_data;

  // Lanes whose source would change are the ones that must break.
  always_comb begin
    map_diff = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      map_diff[i] = (new_map[i*SEL_W +: SEL_W] != active_map_q[i*SEL_W +: SEL_W]);
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    break_mask_d  = break_mask_q;
    active_map_d  = active_map_q;
    pending_map_d = pending_map_q;
    settle_d      = settle_wr ? set_data[15:0] : settle_q;
    // Registered alongside the lane flops so busy lines up with the safe outputs.
    busy_d        = hold || (state_q == ST_SETTLE);

    if (hold) begin
      // Hold keeps reloading the counter; the settle only starts once hold drops.
      state_d      = ST_SETTLE;
      break_mask_d = '1;
      cnt_d        = settle_q;
      if (map_wr) pending_map_d = new_map;
    end else if (state_q == ST_RUN) begin
      if (map_wr && (map_diff != '0)) begin
        pending_map_d = new_map;
        break_mask_d  = map_diff;
        cnt_d         = settle_q;
        state_d       = ST_SETTLE;
      end
    end else if (map_wr) begin
      // Re-map during settle: widen the break set and restart the full settle.
      pending_map_d = new_map;
      break_mask_d  = break_mask_q | map_diff;
      cnt_d         = settle_q;
    end else if (cnt_q == '0) begin
      // Commit the whole map at once; broken lanes stay safe one more cycle via the lane flop.
      active_map_d = pending_map_q;
      break_mask_d = '0;
      state_d      = ST_RUN;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge radio_clk or negedge radio_rst_n) begin
    if (!radio_rst_n) begin
      state_q       <= ST_SETTLE;
      cnt_q         <= SETTLE_CYCLES;
      settle_q      <= SETTLE_CYCLES;
      break_mask_q  <= '1;
      active_map_q  <= IDENT_MAP;
      pending_map_q <= IDENT_MAP;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      settle_q      <= settle_d;
      break_mask_q  <= break_mask_d;
      active_map_q  <= active_map_d;
      pending_map_q <= pending_map_d;
      busy_q        <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    fe_atr_lane #(
      .NUM_CH   (NUM_CH),
      .WIDTH    (WIDTH),
      .SAFE_VAL (SAFE_VAL)
    ) u_lane (
      .radio_clk   (radio_clk),
      .radio_rst_n (radio_rst_n),
      .radio_gpio  (radio_gpio),
      .sel         (active_map_q[i*SEL_W +: SEL_W]),
      .force_safe  (hold || break_mask_q[i]),
      .fe_dat      (fe_gpio[i*WIDTH +: WIDTH])
    );
  end

  assign busy = busy_q;

  // With 8 channels the map fills all 32 bits; busy still owns bit 31.
  always_comb begin
    rb_map            = '0;
    rb_map[MAP_W-1:0] = active_map_q;
    rb_map[31]        = busy_q;
  end

endmodule

// File: tb/tb_fe_atr_router.sv
// Purpose : self-checking bench for fe_atr_router with a timestamp-based reference model.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fe_atr_router;

  localparam int          NCH      = 4;
  localparam int          W        = 8;
  localparam int          SRB      = 'h40;
  localparam logic [7:0]  SAFE     = 8'hA5;
  localparam logic [31:0] SAFE_ALL = {NCH{SAFE}};
  localparam int          SETTLE0  = 16;

  logic          radio_clk = 1'b0;
  logic          radio_rst_n;
  logic          set_stb;
  logic [7:0]    set_addr;
  logic [31:0]   set_data;
  logic          hold;
  logic [31:0]   radio_gpio;
  logic [31:0]   fe_gpio;
  logic          busy;
  logic [31:0]   rb_map;

  always #5 radio_clk = ~radio_clk;

  fe_atr_router #(
    .NUM_CH        (NCH),
    .WIDTH         (W),
    .SR_BASE       (SRB),
    .SAFE_VAL      (SAFE),
    .SETTLE_CYCLES (16'(SETTLE0))
  ) dut (
    .radio_clk   (radio_clk),
    .radio_rst_n (radio_rst_n),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .hold        (hold),
    .radio_gpio  (radio_gpio),
    .fe_gpio     (fe_gpio),
    .busy        (busy),
    .rb_map      (rb_map)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: a remap or hold at edge R schedules the map commit for edge R+settle+1;
  // a lane is safe while it is in the broken set or hold is sampled.
  int          m_active[NCH];
  int          m_pending[NCH];
  bit          m_broken[NCH];
  bit          m_in_settle;
  int          m_settle;
  int          m_ecnt;
  int          m_commit_at;
  logic [31:0] exp_fe;
  logic        exp_busy;
  logic [31:0] exp_rb;

  function automatic logic [31:0] model_rb(input logic b);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i*4 +: 4] = 4'(m_active[i]);
    r[31] = b;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_active[i]  = i;
      m_pending[i] = i;
      m_broken[i]  = 1'b1;
    end
    m_in_settle = 1'b1;
    m_settle    = SETTLE0;
    m_ecnt      = 0;
    m_commit_at = SETTLE0 + 1;
    exp_fe      = SAFE_ALL;
    exp_busy    = 1'b1;
    exp_rb      = model_rb(1'b1);
  endtask

  task automatic model_edge();
    bit is_map, is_set, any_diff, reload;
    int nf[NCH];
    bit df[NCH];
    m_ecnt++;
    is_map   = set_stb && (set_addr == 8'(SRB));
    is_set   = set_stb && (set_addr == 8'(SRB + 1));
    any_diff = 1'b0;
    reload   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      nf[i] = int'(set_data[i*4 +: 4]);
      df[i] = (nf[i] != m_active[i]);
      any_diff |= df[i];
    end
    for (int i = 0; i < NCH; i++) begin
      if (hold || m_broken[i] || m_active[i] >= NCH) exp_fe[i*W +: W] = SAFE;
      else exp_fe[i*W +: W] = radio_gpio[m_active[i]*W +: W];
    end
    exp_busy = hold || m_in_settle;
    if (hold) begin
      if (is_map) for (int i = 0; i < NCH; i++) m_pending[i] = nf[i];
      for (int i = 0; i < NCH; i++) m_broken[i] = 1'b1;
      m_in_settle = 1'b1;
      reload = 1'b1;
    end else if (!m_in_settle) begin
      if (is_map && any_diff) begin
        for (int i = 0; i < NCH; i++) begin
          m_pending[i] = nf[i];
          m_broken[i]  = df[i];
        end
        m_in_settle = 1'b1;
        reload = 1'b1;
      end
    end else if (is_map) begin
      for (int i = 0; i < NCH; i++) begin
        m_pending[i] = nf[i];
        m_broken[i]  = m_broken[i] | df[i];
      end
      reload = 1'b1;
    end else if (m_ecnt == m_commit_at) begin
      for (int i = 0; i < NCH; i++) begin
        m_active[i] = m_pending[i];
        m_broken[i] = 1'b0;
      end
      m_in_settle = 1'b0;
    end
    if (reload) m_commit_at = m_ecnt + m_settle + 1;
    if (is_set) m_settle = int'(set_data[15:0]);
    exp_rb = model_rb(exp_busy);
  endtask

  // Radio words never equal SAFE so a safe output is unambiguous.
  function automatic logic [31:0] rand_radio();
    logic [31:0] v;
    logic [7:0]  b;
    for (int i = 0; i < NCH; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SAFE) b = ~b;
      v[i*W +: W] = b;
    end
    return v;
  endfunction

  task automatic step();
    radio_gpio = rand_radio();
    @(posedge radio_clk);
    model_edge();
    @(negedge radio_clk);
    check_eq("fe_gpio", fe_gpio, exp_fe);
    check_eq("busy", {31'b0, busy}, {31'b0, exp_busy});
    check_eq("rb_map", rb_map, exp_rb);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    step();
    set_stb  = 1'b0;
  endtask

  int cnt_a, cnt_b;

  initial begin
    radio_rst_n = 1'b0;
    set_stb     = 1'b0;
    set_addr    = '0;
    set_data    = '0;
    hold        = 1'b0;
    radio_gpio  = rand_radio();
    model_reset();
    repeat (3) @(negedge radio_clk);
    check_eq("rst_fe", fe_gpio, SAFE_ALL);
    check_eq("rst_busy", {31'b0, busy}, 32'd1);
    check_eq("rst_rb", rb_map, 32'h8000_3210);
    radio_rst_n = 1'b1;
    model_reset();

    // Reset release: 17 safe cycles then identity routing.
    cnt_a = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (fe_gpio[7:0] == SAFE) cnt_a++;
    end
    check_eq("rel_safe_cycles", cnt_a, 17);
    check_eq("rel_rb", rb_map, 32'h0000_3210);

    // Swap fe0/fe1 with settle 4.
    wr(8'(SRB + 1), 32'd4);
    wr(8'(SRB), 32'h0000_3201);
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (busy) cnt_a++;
      if (fe_gpio[7:0] == SAFE) cnt_b++;
    end
    check_eq("swap_busy_cycles", cnt_a, 5);
    check_eq("swap_fe0_safe", cnt_b, 5);
    check_eq("swap_rb", rb_map, 32'h0000_3201);

    // Second remap two cycles into a 10-cycle settle restarts the count.
    wr(8'(SRB + 1), 32'd10);
    wr(8'(SRB), 32'h0000_3210);
    step();
    wr(8'(SRB), 32'h0000_2301);
    cnt_a = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (fe_gpio[31:24] == SAFE) cnt_a++;
    end
    check_eq("restart_fe3_safe", cnt_a, 11);
    check_eq("restart_rb", rb_map, 32'h0000_2301);

    // Three-cycle hold pulse with settle 2.
    wr(8'(SRB + 1), 32'd2);
    cnt_a = 0;
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (fe_gpio[31:24] == SAFE) cnt_a++;
    end
    hold = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (fe_gpio[31:24] == SAFE) cnt_a++;
    end
    check_eq("hold_fe3_safe", cnt_a, 6);
    check_eq("hold_rb", rb_map, 32'h0000_2301);

    // Invalid index on fe1, then an identical map (junk upper bits) must not pulse busy.
    wr(8'(SRB), 32'h0000_23F1);
    repeat (6) step();
    cnt_a = 0;
    wr(8'(SRB), 32'hDEAD_23F1);
    for (int k = 0; k < 6; k++) begin
      step();
      if (busy) cnt_a++;
    end
    check_eq("same_map_busy", cnt_a, 0);
    check_eq("invalid_fe1", {24'b0, fe_gpio[15:8]}, {24'b0, SAFE});

    // Asynchronous reset in the middle of a settle.
    wr(8'(SRB + 1), 32'd8);
    wr(8'(SRB), 32'h0000_0123);
    repeat (3) step();
    #2 radio_rst_n = 1'b0;
    #1;
    check_eq("arst_fe", fe_gpio, SAFE_ALL);
    check_eq("arst_busy", {31'b0, busy}, 32'd1);
    check_eq("arst_rb", rb_map, 32'h8000_3210);
    @(negedge radio_clk);
    radio_rst_n = 1'b1;
    model_reset();

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      int r;
      if (!hold) hold = ($urandom_range(0, 39) == 0);
      else       hold = ($urandom_range(0, 2) != 0);
      set_stb = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      if (r < 6) begin
        set_addr = 8'(SRB);
        set_data = $urandom();
        for (int i = 0; i < NCH; i++) begin
          if ($urandom_range(0, 9) < 9) set_data[i*4 +: 4] = 4'($urandom_range(0, NCH - 1));
          else                          set_data[i*4 +: 4] = 4'($urandom_range(NCH, 15));
        end
      end else if (r < 8) begin
        set_addr = 8'(SRB + 1);
        set_data = {$urandom_range(0, 65535), 16'($urandom_range(0, 7))};
      end else begin
        set_addr = 8'(SRB + 2 + $urandom_range(0, 13));
        set_data = $urandom();
      end
      step();
      set_stb = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
